// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, FSM state
// codes, mode encodings and CTRL bit positions.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  localparam int TC_EN      = 0;
  localparam int TC_MODE_LO = 1;
  localparam int TC_MODE_HI = 2;
  localparam int TC_IM      = 3;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: word select, write strobe, data in/out, and
// the interrupt line toward cp0.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with one-shot / auto-reload modes; raises a
// registered interrupt request when the count expires.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter bit IM_RST = 1'b0
) (
  input logic              clk,
  input logic              reset,
  timer_counter_if.slave   bus
);

  tc_state_e        state_reg, state_next;
  logic             en_reg, en_next;
  logic [1:0]       mode_reg, mode_next;
  logic             im_reg, im_next;
  logic [CNT_W-1:0] preset_reg, preset_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             irq_flag_reg, irq_flag_next;
  logic             ctrl_wr;
  logic             preset_wr;

  assign ctrl_wr   = bus.we && (bus.addr == TC_CTRL);
  assign preset_wr = bus.we && (bus.addr == TC_PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= TC_IDLE;
      en_reg       <= 1'b0;
      mode_reg     <= TC_MODE_ONESHOT;
      im_reg       <= IM_RST;
      preset_reg   <= '0;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      en_reg       <= en_next;
      mode_reg     <= mode_next;
      im_reg       <= im_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    en_next       = en_reg;
    mode_next     = mode_reg;
    im_next       = im_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    irq_flag_next = irq_flag_reg;

    case (state_reg)
      TC_IDLE: if (en_reg) state_next = TC_LOAD;
      TC_LOAD: begin
        count_next = preset_reg;
        state_next = TC_CNT;
      end
      TC_CNT: begin
        if (!en_reg) begin
          state_next = TC_IDLE;
        end else if (count_reg > CNT_W'(1)) begin
          count_next = count_reg - CNT_W'(1);
        end else begin
          count_next    = '0;
          irq_flag_next = 1'b1;
          state_next    = TC_INT;
        end
      end
      TC_INT: begin
        // Only mode 01 reloads; 10/11 fall back to one-shot behaviour.
        if (mode_reg == TC_MODE_RELOAD) begin
          irq_flag_next = 1'b0;
          state_next    = TC_LOAD;
        end else begin
          en_next    = 1'b0;
          state_next = TC_IDLE;
        end
      end
      default: state_next = TC_IDLE;
    endcase

    if (preset_wr) preset_next = bus.din[CNT_W-1:0];

    // CPU writes to CTRL override the FSM: they acknowledge the interrupt and,
    // with Enable low, park the counter in IDLE with COUNT frozen.
    if (ctrl_wr) begin
      en_next       = bus.din[TC_EN];
      mode_next     = bus.din[TC_MODE_HI:TC_MODE_LO];
      im_next       = bus.din[TC_IM];
      irq_flag_next = 1'b0;
      if (!bus.din[TC_EN]) begin
        state_next = TC_IDLE;
        count_next = count_reg;
      end
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      TC_CTRL:   bus.dout = {28'd0, im_reg, mode_reg, en_reg};
      TC_PRESET: bus.dout = 32'(preset_reg);
      TC_COUNT:  bus.dout = 32'(count_reg);
      default:   bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = im_reg & irq_flag_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a per-cycle vector table plus hand-written
// sequences for reload, acknowledge, override and asynchronous reset cases.
module tb_timer_counter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  timer_counter_if bus ();

  timer_counter #(.CNT_W(32), .IM_RST(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, let the rising edge act, sample 1ns later.
  task automatic cyc(input logic [1:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.we   = w;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    $display("cycle t=%0t addr=%0d we=%0b din=%08h -> dout=%08h irq=%0b",
             $time, a, w, d, bus.dout, bus.irq);
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget, input string name);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(2'd2, 1'b0, 32'd0);
      if (bus.dout == target) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_irq(input int budget, input string name);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(2'd2, 1'b0, 32'd0);
      if (bus.irq === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    vecs = '{
      '{2'd1, 1'b1, 32'd5,          32'd5,  1'b0},  // PRESET=5
      '{2'd0, 1'b1, 32'h9,          32'h9,  1'b0},  // one-shot, IM, En (edge t)
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b0},  // t+1 LOAD
      '{2'd2, 1'b0, 32'd0,          32'd5,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd4,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd3,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd2,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd1,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b1},  // t+7 IRQ
      '{2'd0, 1'b0, 32'd0,          32'h8,  1'b1},  // Enable self-cleared
      '{2'd0, 1'b0, 32'd0,          32'h8,  1'b1},  // sticky
      '{2'd0, 1'b1, 32'h8,          32'h8,  1'b0},  // acknowledge
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b0},
      '{2'd3, 1'b1, 32'hFFFF_FFFF,  32'd0,  1'b0},  // reserved offset
      '{2'd2, 1'b1, 32'h0000_1234,  32'd0,  1'b0},  // COUNT is read-only
      '{2'd0, 1'b1, 32'hFFFF_FFF0,  32'd0,  1'b0},  // upper CTRL bits dropped
      '{2'd1, 1'b1, 32'd3,          32'd3,  1'b0},  // PRESET=3
      '{2'd0, 1'b1, 32'hB,          32'hB,  1'b0},  // reload, IM, En
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd3,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd2,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd1,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b1},  // first pulse
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b0},  // LOAD
      '{2'd2, 1'b0, 32'd0,          32'd3,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd2,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd1,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b1},  // second pulse, 5 cycles later
      '{2'd2, 1'b0, 32'd0,          32'd0,  1'b0},
      '{2'd2, 1'b0, 32'd0,          32'd3,  1'b0},
      '{2'd0, 1'b1, 32'h0,          32'h0,  1'b0}   // stop
    };

    reset    = 1'b1;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", bus.dout, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    bus.addr = 2'd1; #1;
    check("rst_preset", bus.dout, 32'd0);
    bus.addr = 2'd2; #1;
    check("rst_count", bus.dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      cyc(vecs[i].addr, vecs[i].we, vecs[i].din);
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
    end

    // PRESET rewritten mid-count: current period undisturbed, next period uses 2.
    cyc(2'd1, 1'b1, 32'd20);
    cyc(2'd0, 1'b1, 32'hB);
    wait_count(32'd10, 40, "reach_count10");
    cyc(2'd1, 1'b1, 32'd2);
    check("mid_preset", bus.dout, 32'd2);
    bus.addr = 2'd2; #1;
    check("mid_count9", bus.dout, 32'd9);
    cyc(2'd2, 1'b0, 32'd0);
    check("mid_count8", bus.dout, 32'd8);
    wait_irq(20, "mid_irq_seen");
    cyc(2'd2, 1'b0, 32'd0);
    check("mid_load_irq", {31'd0, bus.irq}, 32'd0);
    cyc(2'd2, 1'b0, 32'd0);
    check("reload_count2", bus.dout, 32'd2);
    cyc(2'd2, 1'b0, 32'd0);
    check("reload_count1", bus.dout, 32'd1);
    cyc(2'd2, 1'b0, 32'd0);
    check("reload_irq", {31'd0, bus.irq}, 32'd1);
    cyc(2'd0, 1'b1, 32'h0);

    // Masked completion, then enabling IM with a CTRL write must not expose the old flag.
    cyc(2'd1, 1'b1, 32'd4);
    cyc(2'd0, 1'b1, 32'h1);
    repeat (8) cyc(2'd2, 1'b0, 32'd0);
    check("masked_count", bus.dout, 32'd0);
    check("masked_irq", {31'd0, bus.irq}, 32'd0);
    cyc(2'd0, 1'b0, 32'd0);
    check("masked_en_cleared", bus.dout, 32'h0);
    cyc(2'd0, 1'b1, 32'h9);
    check("unmask_irq", {31'd0, bus.irq}, 32'd0);
    check("unmask_ctrl", bus.dout, 32'h9);
    cyc(2'd2, 1'b0, 32'd0);
    check("unmask_irq_next", {31'd0, bus.irq}, 32'd0);
    cyc(2'd0, 1'b1, 32'h0);

    // CPU write in INT (one-shot) wins over the FSM clearing Enable.
    cyc(2'd1, 1'b1, 32'd1);
    cyc(2'd0, 1'b1, 32'h9);
    repeat (3) cyc(2'd2, 1'b0, 32'd0);
    check("race_irq_set", {31'd0, bus.irq}, 32'd1);
    cyc(2'd0, 1'b1, 32'hB);
    check("race_ctrl", bus.dout, 32'hB);
    check("race_irq_ack", {31'd0, bus.irq}, 32'd0);
    cyc(2'd0, 1'b1, 32'h0);

    // Disabling mid-count freezes COUNT.
    cyc(2'd1, 1'b1, 32'd6);
    cyc(2'd0, 1'b1, 32'h1);
    repeat (3) cyc(2'd2, 1'b0, 32'd0);
    check("dis_count5", bus.dout, 32'd5);
    cyc(2'd0, 1'b1, 32'h0);
    bus.addr = 2'd2; #1;
    check("dis_hold", bus.dout, 32'd5);
    cyc(2'd2, 1'b0, 32'd0);
    check("dis_hold2", bus.dout, 32'd5);

    // Asynchronous reset while counting.
    cyc(2'd1, 1'b1, 32'd5);
    cyc(2'd0, 1'b1, 32'h9);
    wait_count(32'd3, 20, "reach_count3");
    #3 reset = 1'b1;
    #1;
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    check("arst_count", bus.dout, 32'd0);
    bus.addr = 2'd0; #1;
    check("arst_ctrl", bus.dout, 32'd0);
    bus.addr = 2'd1; #1;
    check("arst_preset", bus.dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset drops a pending IRQ without waiting for a clock.
    cyc(2'd1, 1'b1, 32'd1);
    cyc(2'd0, 1'b1, 32'h9);
    wait_irq(10, "pre_reset_irq");
    #3 reset = 1'b1;
    #1;
    check("arst_irq_drop", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
